rlc_sram_reader: RTL and testbench

- Downstream neighbour of the RLC encoder. Reads the packed 99-bit RLC words, one per 8x8 block, from the RLC SRAM at addresses 0..NUM_BLOCKS-1.
- Unpacks each word into DC/R/L/F fields and counts the live (R,L) pairs.
- Streams the result to the entropy/packing stage over a valid/ready handshake.
- A small prefetch buffer hides the 1-cycle SRAM read latency, sustaining 1 block/cycle.

---
 rtl/rlc_sram_reader.sv | 178 +++++++++++++++++
 tb/tb_rlc_sram_reader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rlc_sram_reader.sv
// RLC SRAM reader: fetches one packed 99-bit RLC word per block, unpacks it,
// counts live (R,L) pairs and streams the result over valid/ready.
//
// state | meaning
// IDLE  | waiting for start; start issues the read of address 0
// RUN   | issuing reads whenever the output buffer has room
// DRAIN | all reads issued; emptying the buffer
// DONE  | one-cycle done pulse, then back to IDLE
module rlc_sram_reader #(
    parameter int NUM_BLOCKS = 1729,
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 99,
    parameter int DEPTH      = 2
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              start,
    output logic              sram_ren,
    output logic [ADDR_W-1:0] sram_raddr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [10:0]       out_dc,
    output logic [23:0]       out_r,
    output logic [31:0]       out_l,
    output logic [31:0]       out_f,
    output logic [3:0]        out_pairs,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    // One slot beyond DEPTH absorbs the word already inside the SRAM pipe
    // when the consumer stalls, so full throughput never risks overflow.
    localparam int SLOTS = DEPTH + 1;
    localparam int PTR_W = $clog2(SLOTS);
    localparam int CNT_W = $clog2(SLOTS + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BLOCKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [10:0]       dc;
        logic [23:0]       r;
        logic [31:0]       l;
        logic [31:0]       f;
        logic [3:0]        pairs;
        logic [ADDR_W-1:0] idx;
        logic              last;
    } entry_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] issue_cnt_q, issue_cnt_d;
    logic              ren_q, ren_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              cap_q;
    logic [ADDR_W-1:0] cap_idx_q;
    entry_t            fifo_q [SLOTS];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              push, pop, issue, room;
    logic [CNT_W:0]    occ_sum;
    entry_t            cap_entry, head;

    function automatic logic [3:0] count_pairs(input logic [31:0] f);
        logic [3:0] n;
        n = '0;
        for (int k = 0; k < 8; k++) begin
            n = n + {3'b000, |f[4*k +: 4]};
        end
        return n;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SLOTS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign push      = cap_q;
    assign occ_sum   = {1'b0, count_q} + {{CNT_W{1'b0}}, ~ren_q} - {{CNT_W{1'b0}}, pop};
    assign room      = (occ_sum < (CNT_W + 1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (srst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (LAST_ADDR == '0) ? S_DRAIN : S_RUN;
            S_RUN:   if (room && issue_cnt_q == LAST_ADDR) state_d = S_DRAIN;
            S_DRAIN: if (pop && head.last && count_q == CNT_W'(1) && !cap_q && ren_q)
                         state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        issue       = 1'b0;
        issue_cnt_d = issue_cnt_q;
        raddr_d     = raddr_q;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    issue       = 1'b1;
                    raddr_d     = '0;
                    issue_cnt_d = ADDR_W'(1);
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (room) begin
                    issue       = 1'b1;
                    raddr_d     = issue_cnt_q;
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
        ren_d = ~issue;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ren_q       <= 1'b1;
            raddr_q     <= '0;
            issue_cnt_q <= '0;
            cap_q       <= 1'b0;
            cap_idx_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            ren_q       <= ren_d;
            raddr_q     <= raddr_d;
            issue_cnt_q <= issue_cnt_d;
            cap_q       <= ~ren_q;
            cap_idx_q   <= raddr_q;
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q     <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_comb begin
        cap_entry.dc    = sram_rdata[98:88];
        cap_entry.r     = sram_rdata[87:64];
        cap_entry.l     = sram_rdata[63:32];
        cap_entry.f     = sram_rdata[31:0];
        cap_entry.pairs = count_pairs(sram_rdata[31:0]);
        cap_entry.idx   = cap_idx_q;
        cap_entry.last  = (cap_idx_q == LAST_ADDR);
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= cap_entry;
    end

    assign head       = out_valid ? fifo_q[rd_ptr_q] : '0;
    assign out_dc     = head.dc;
    assign out_r      = head.r;
    assign out_l      = head.l;
    assign out_f      = head.f;
    assign out_pairs  = head.pairs;
    assign out_idx    = head.idx;
    assign out_last   = head.last;
    assign sram_ren   = ren_q;
    assign sram_raddr = raddr_q;

endmodule

// File: tb/tb_rlc_sram_reader.sv
// Directed bench for rlc_sram_reader: a 4-block instance for timing, unpacking,
// start filtering and mid-run reset, and a full-size instance for a long run.
module tb_rlc_sram_reader;

    logic        clk = 1'b0;
    logic        srst;
    int          total = 0;
    int          bad   = 0;
    int          mode;

    logic        start_s, ren_s, valid_s, ready_s, last_s, busy_s, done_s;
    logic [10:0] raddr_s, dc_s, idx_s;
    logic [98:0] rdata_s;
    logic [23:0] r_s;
    logic [31:0] l_s, f_s;
    logic [3:0]  pairs_s;

    logic        start_b, ren_b, valid_b, ready_b, last_b, busy_b, done_b;
    logic [10:0] raddr_b, dc_b, idx_b;
    logic [98:0] rdata_b;
    logic [23:0] r_b;
    logic [31:0] l_b, f_b;
    logic [3:0]  pairs_b;

    always #5 clk = ~clk;

    rlc_sram_reader #(.NUM_BLOCKS(4)) dut_s (
        .clk(clk), .srst(srst), .start(start_s),
        .sram_ren(ren_s), .sram_raddr(raddr_s), .sram_rdata(rdata_s),
        .out_valid(valid_s), .out_ready(ready_s),
        .out_dc(dc_s), .out_r(r_s), .out_l(l_s), .out_f(f_s),
        .out_pairs(pairs_s), .out_idx(idx_s), .out_last(last_s),
        .busy(busy_s), .done(done_s)
    );

    rlc_sram_reader dut_b (
        .clk(clk), .srst(srst), .start(start_b),
        .sram_ren(ren_b), .sram_raddr(raddr_b), .sram_rdata(rdata_b),
        .out_valid(valid_b), .out_ready(ready_b),
        .out_dc(dc_b), .out_r(r_b), .out_l(l_b), .out_f(f_b),
        .out_pairs(pairs_b), .out_idx(idx_b), .out_last(last_b),
        .busy(busy_b), .done(done_b)
    );

    function automatic logic [98:0] word_s(input logic [10:0] a, input int m);
        if (m == 0) return {a, 88'h0};
        case (a)
            11'd0:   return {11'd5, 24'o76543210, 32'h1234_5678, 32'h0000_0111};
            11'd1:   return {11'd1, 24'o1, 32'h0, 32'h0};
            11'd2:   return {11'd2, 24'd0, 32'hFFFF_0000, 32'h1111_1111};
            default: return {11'h7FF, 24'hFF_FFFF, 32'h0, 32'hF000_000F};
        endcase
    endfunction

    always @(posedge clk) begin
        if (!ren_s) rdata_s <= word_s(raddr_s, mode);
        if (!ren_b) rdata_b <= {raddr_b, 88'h0};
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_idx, dones;
        bit finished, drain_pulsed;

        mode = 0;
        srst = 1'b1; start_s = 1'b0; ready_s = 1'b1; start_b = 1'b0; ready_b = 1'b1;
        repeat (3) tick();
        chk("rst_ren", ren_s, 1);
        chk("rst_raddr", raddr_s, 0);
        chk("rst_valid", valid_s, 0);
        chk("rst_busy", busy_s, 0);
        chk("rst_done", done_s, 0);
        chk("rst_fields", {dc_s, r_s, l_s, f_s, pairs_s, idx_s, last_s}, 0);
        chk("rst_ren_b", ren_b, 1);
        srst = 1'b0;
        tick();

        // basic run: start sampled in cycle T
        start_s = 1'b1;
        tick();                                   // T+1
        start_s = 1'b0;
        chk("t1_ren1", ren_s, 0);
        chk("t1_addr1", raddr_s, 0);
        chk("t1_busy1", busy_s, 1);
        chk("t1_valid1", valid_s, 0);
        tick();                                   // T+2
        chk("t1_addr2", raddr_s, 1);
        chk("t1_valid2", valid_s, 0);
        tick();                                   // T+3
        chk("t1_addr3", raddr_s, 2);
        chk("t1_out3", {valid_s, dc_s, idx_s, last_s}, {1'b1, 11'd0, 11'd0, 1'b0});
        tick();                                   // T+4
        chk("t1_addr4", {ren_s, raddr_s}, {1'b0, 11'd3});
        chk("t1_out4", {valid_s, dc_s, idx_s, last_s}, {1'b1, 11'd1, 11'd1, 1'b0});
        tick();                                   // T+5
        chk("t1_ren5", {ren_s, raddr_s}, {1'b1, 11'd3});
        chk("t1_out5", {valid_s, dc_s, idx_s, last_s}, {1'b1, 11'd2, 11'd2, 1'b0});
        tick();                                   // T+6
        chk("t1_out6", {valid_s, dc_s, idx_s, last_s}, {1'b1, 11'd3, 11'd3, 1'b1});
        chk("t1_done6", {busy_s, done_s}, 2'b10);
        tick();                                   // T+7
        chk("t1_done7", {busy_s, done_s, valid_s}, 3'b010);
        tick();                                   // T+8
        chk("t1_done8", done_s, 0);

        // unpacking, with stray starts in RUN and DRAIN
        mode = 1;
        start_s = 1'b1;
        tick();                                   // T+1
        start_s = 1'b0;
        chk("t2_restart", {ren_s, raddr_s}, {1'b0, 11'd0});
        tick();                                   // T+2 (RUN)
        start_s = 1'b1;
        tick();                                   // T+3
        start_s = 1'b0;
        chk("t2_w0_dc", dc_s, 5);
        chk("t2_w0_r", r_s, 24'o76543210);
        chk("t2_w0_l", l_s, 32'h1234_5678);
        chk("t2_w0_f", f_s, 32'h0000_0111);
        chk("t2_w0_pairs", pairs_s, 3);
        tick();                                   // T+4
        chk("t2_w1", {valid_s, dc_s, r_s, pairs_s, idx_s}, {1'b1, 11'd1, 24'o1, 4'd0, 11'd1});
        tick();                                   // T+5 (DRAIN)
        start_s = 1'b1;
        chk("t2_w2", {l_s, f_s, pairs_s, idx_s}, {32'hFFFF_0000, 32'h1111_1111, 4'd8, 11'd2});
        tick();                                   // T+6
        start_s = 1'b0;
        chk("t2_w3", {dc_s, r_s, pairs_s, last_s}, {11'h7FF, 24'hFF_FFFF, 4'd2, 1'b1});
        chk("t2_noissue", ren_s, 1);
        tick();                                   // T+7
        chk("t2_done", {done_s, busy_s}, 2'b10);
        tick();                                   // T+8
        chk("t2_idle", {done_s, busy_s, ren_s, valid_s}, 4'b0010);

        // reset with one read landing and two words buffered
        mode = 0;
        ready_s = 1'b0;
        start_s = 1'b1;
        tick();                                   // T+1
        start_s = 1'b0;
        tick();                                   // T+2
        tick();                                   // T+3
        chk("t6_fill3", {valid_s, idx_s, ren_s, raddr_s}, {1'b1, 11'd0, 1'b0, 11'd2});
        tick();                                   // T+4
        chk("t6_stall4", {valid_s, idx_s, ren_s, raddr_s}, {1'b1, 11'd0, 1'b1, 11'd2});
        srst = 1'b1;
        tick();                                   // T+5
        srst = 1'b0;
        chk("t6_after", {valid_s, ren_s, busy_s, done_s, raddr_s, idx_s}, {4'b0100, 11'd0, 11'd0});
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done_s || valid_s) dones++;
        end
        chk("t6_quiet", dones, 0);
        ready_s = 1'b1;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        chk("t6_restart", {ren_s, raddr_s}, {1'b0, 11'd0});
        exp_idx = 0;
        dones = 0;
        for (int i = 0; i < 20 && dones == 0; i++) begin
            if (valid_s) begin
                chk("t6_idx", idx_s, exp_idx);
                exp_idx++;
            end
            if (done_s) dones++;
            tick();
        end
        chk("t6_count", exp_idx, 4);
        chk("t6_done", dones, 1);

        // full-size run: early stall, then random backpressure
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        exp_idx = 0;
        dones = 0;
        finished = 0;
        drain_pulsed = 0;
        for (int cyc = 1; cyc <= 8000 && !finished; cyc++) begin
            if (cyc < 10)       ready_b = 1'b1;
            else if (cyc <= 15) ready_b = 1'b0;
            else                ready_b = ($urandom_range(0, 3) != 0);
            start_b = 1'b0;
            if (cyc == 50) start_b = 1'b1;
            if (valid_b && last_b && !drain_pulsed) begin
                start_b = 1'b1;
                drain_pulsed = 1;
            end
            if (cyc >= 11 && cyc <= 15) begin
                chk("t3_noissue", ren_b, 1);
                chk("t3_hold", {valid_b, idx_b, dc_b}, {1'b1, 11'(exp_idx), 11'(exp_idx)});
            end
            if (valid_b && ready_b) begin
                chk("t4_idx", idx_b, exp_idx);
                chk("t4_dc", dc_b, exp_idx);
                chk("t4_last", last_b, exp_idx == 1728);
                exp_idx++;
            end
            if (done_b) begin
                dones++;
                finished = 1;
            end
            tick();
        end
        start_b = 1'b0;
        chk("t4_count", exp_idx, 1729);
        chk("t4_done_seen", dones, 1);
        chk("t4_idle", {done_b, busy_b, valid_b, ren_b}, 4'b0001);
        tick();
        chk("t4_no_relaunch", {busy_b, ren_b}, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
